// File: rtl/memory_read_arbiter.sv
// memory_read_arbiter
//   Arbitrates burst read requests from two requesters (0 = dcache,
//   1 = icache) onto a single AXI4 read channel. It has one AR slot.
//   Each requester may have up to MAX_OUTSTANDING bursts in flight.
//   R beats are registered and routed back by rid. A beat whose rid has
//   no outstanding burst is dropped.
//
//   Ports
//     clk, rst                      clock, async active-high reset
//     req0Valid/req0Addr/req0Ready  requester 0 request and grant (grant is combinational)
//     req1Valid/req1Addr/req1Ready  requester 1 request and grant
//     resp0Valid/resp1Valid         registered read beat strobe per requester
//     respData/respLast             shared registered beat data / last flag
//     arvalid/arready/araddr/arid/arlen   AXI4 AR channel
//     rvalid/rid/rdata/rlast/rready       AXI4 R channel
//
//   Configuration
//     RSD_MEM_READ_ARB_ROUND_ROBIN_EN  defined: round-robin priority.
//                                      undefined: requester 0 always wins.
//
//   state   | meaning
//   IDLE    | AR slot empty, arvalid low
//   PENDING | AR slot holds a request, arvalid high until arready

module memory_read_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_LEN       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0Valid,
  input  logic [ADDR_WIDTH-1:0] req0Addr,
  output logic                  req0Ready,
  input  logic                  req1Valid,
  input  logic [ADDR_WIDTH-1:0] req1Addr,
  output logic                  req1Ready,
  output logic                  resp0Valid,
  output logic                  resp1Valid,
  output logic [DATA_WIDTH-1:0] respData,
  output logic                  respLast,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arid,
  output logic [7:0]            arlen,
  input  logic                  rvalid,
  input  logic                  rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  output logic                  rready
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] LAST_FREE = CW'(MAX_OUTSTANDING - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state, nextState;

  logic [CW-1:0] outstanding0, outstanding1;
  logic arHandshake, slotFree, rAccept;
  logic inc0, inc1, dec0, dec1;
  logic elig0, elig1, grant0, grant1;
  logic prefer1;

  assign arvalid     = (state == PENDING);
  assign arlen       = 8'(BURST_LEN - 1);
  assign rready      = ~rst;
  assign arHandshake = arvalid && arready;
  assign slotFree    = (state == IDLE) || arHandshake;

  // Beats for a requester with nothing in flight are stray and ignored.
  assign rAccept = rvalid && rready && (rid ? (outstanding1 != '0) : (outstanding0 != '0));

  assign inc0 = arHandshake && !arid;
  assign inc1 = arHandshake && arid;
  assign dec0 = rAccept && rlast && !rid;
  assign dec1 = rAccept && rlast && rid;

  // An AR handshake this cycle that fills the last free slot already blocks
  // a new grant, so the slot can never push a counter past the limit.
  assign elig0 = req0Valid && (outstanding0 < MAX_CNT) &&
                 !(inc0 && !dec0 && (outstanding0 == LAST_FREE));
  assign elig1 = req1Valid && (outstanding1 < MAX_CNT) &&
                 !(inc1 && !dec1 && (outstanding1 == LAST_FREE));

`ifdef RSD_MEM_READ_ARB_ROUND_ROBIN_EN
  // prioPtr names the requester that wins a tie; it flips to the other one
  // after every grant.
  logic prioPtr;
  assign prefer1 = prioPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prioPtr <= 1'b0;
    end else if (grant0 || grant1) begin
      prioPtr <= grant0;
    end
  end
`else
  assign prefer1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (slotFree) begin
      if (elig0 && elig1) begin
        grant0 = !prefer1;
        grant1 = prefer1;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
    if (state == IDLE) begin
      if (grant0 || grant1) nextState = PENDING;
    end else begin
      if (arready && !(grant0 || grant1)) nextState = IDLE;
    end
  end

  assign req0Ready = grant0;
  assign req1Ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr <= '0;
      arid   <= 1'b0;
    end else if (grant0) begin
      araddr <= req0Addr;
      arid   <= 1'b0;
    end else if (grant1) begin
      araddr <= req1Addr;
      arid   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding0 <= '0;
      outstanding1 <= '0;
    end else begin
      if (inc0 && !dec0) outstanding0 <= outstanding0 + 1'b1;
      else if (dec0 && !inc0) outstanding0 <= outstanding0 - 1'b1;
      if (inc1 && !dec1) outstanding1 <= outstanding1 + 1'b1;
      else if (dec1 && !inc1) outstanding1 <= outstanding1 - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0Valid <= 1'b0;
      resp1Valid <= 1'b0;
      respLast   <= 1'b0;
      respData   <= '0;
    end else begin
      resp0Valid <= rAccept && !rid;
      resp1Valid <= rAccept && rid;
      respLast   <= rAccept && rlast;
      if (rAccept) respData <= rdata;
    end
  end

endmodule

// File: tb/tb_memory_read_arbiter.sv
module tb_memory_read_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MAXO = 4;

  logic          clk, rst;
  logic          req0Valid, req1Valid, req0Ready, req1Ready;
  logic [AW-1:0] req0Addr, req1Addr;
  logic          resp0Valid, resp1Valid, respLast;
  logic [DW-1:0] respData;
  logic          arvalid, arready, arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          rvalid, rid, rlast, rready;
  logic [DW-1:0] rdata;

  memory_read_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(8), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Ready(req1Ready),
    .resp0Valid(resp0Valid), .resp1Valid(resp1Valid),
    .respData(respData), .respLast(respLast),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .rlast(rlast), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one request slot, integer in-flight counts per
  // requester, the id that wins the next tie, and the last registered beat.
  bit          mBusy;
  logic [31:0] mAddr;
  bit          mId;
  int          mCnt[2];
  int          mPrefer;
  bit          mV0, mV1, mLast;
  logic [63:0] mData;
  int          mNxt[2];
  bit          mHs, mAcc;
  int          mG;

  function automatic void mReset();
    mBusy = 0; mAddr = '0; mId = 0; mCnt[0] = 0; mCnt[1] = 0; mPrefer = 0;
    mV0 = 0; mV1 = 0; mLast = 0; mData = '0; mG = -1; mHs = 0; mAcc = 0;
  endfunction

  // Drive one cycle's inputs, predict the grant and compare every output.
  task automatic apply(input bit v0, input logic [31:0] a0, input bit v1, input logic [31:0] a1,
                       input bit ary, input bit rv, input bit ri, input bit rl, input logic [63:0] rd);
    bit e0, e1;
    req0Valid = v0; req0Addr = a0; req1Valid = v1; req1Addr = a1;
    arready = ary; rvalid = rv; rid = ri; rlast = rl; rdata = rd;
    #1;
    mHs  = mBusy && ary;
    mAcc = rv && (mCnt[ri] > 0);
    for (int n = 0; n < 2; n++)
      mNxt[n] = mCnt[n] + ((mHs && int'(mId) == n) ? 1 : 0) - ((mAcc && rl && int'(ri) == n) ? 1 : 0);
    e0 = v0 && (mCnt[0] < MAXO) && (mNxt[0] < MAXO);
    e1 = v1 && (mCnt[1] < MAXO) && (mNxt[1] < MAXO);
    mG = -1;
    if (!mBusy || mHs) begin
`ifdef RSD_MEM_READ_ARB_ROUND_ROBIN_EN
      if (e0 && e1) mG = mPrefer;
`else
      if (e0 && e1) mG = 0;
`endif
      else if (e0) mG = 0;
      else if (e1) mG = 1;
    end
    chk("req0Ready", req0Ready, 64'(mG == 0));
    chk("req1Ready", req1Ready, 64'(mG == 1));
    chk("arvalid", arvalid, 64'(mBusy));
    chk("araddr", araddr, 64'(mAddr));
    chk("arid", arid, 64'(mId));
    chk("arlen", arlen, 64'd7);
    chk("rready", rready, 64'd1);
    chk("resp0Valid", resp0Valid, 64'(mV0));
    chk("resp1Valid", resp1Valid, 64'(mV1));
    chk("respLast", respLast, 64'(mLast));
    chk("respData", respData, mData);
  endtask

  task automatic step();
    @(posedge clk);
    if (mG >= 0) begin
      mBusy = 1;
      mAddr = (mG == 1) ? req1Addr : req0Addr;
      mId = (mG == 1);
      mPrefer = 1 - mG;
    end else if (mHs) begin
      mBusy = 0;
    end
    mCnt[0] = mNxt[0];
    mCnt[1] = mNxt[1];
    mV0 = mAcc && !rid;
    mV1 = mAcc && rid;
    mLast = mAcc && rlast;
    if (mAcc) mData = rdata;
    @(negedge clk);
  endtask

  task automatic idleIn();
    req0Valid = 0; req1Valid = 0; req0Addr = '0; req1Addr = '0;
    arready = 0; rvalid = 0; rid = 0; rlast = 0; rdata = '0;
  endtask

  // Assert reset between edges and check outputs clear without waiting for a clock.
  task automatic rstPulse();
    rst = 1'b1;
    #1;
    chk("rst_arvalid", arvalid, 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_arid", arid, 64'd0);
    chk("rst_rready", rready, 64'd0);
    chk("rst_resp0Valid", resp0Valid, 64'd0);
    chk("rst_resp1Valid", resp1Valid, 64'd0);
    chk("rst_respData", respData, 64'd0);
    chk("rst_respLast", respLast, 64'd0);
    idleIn();
    mReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit v0; logic [31:0] a0; bit v1; logic [31:0] a1;
    bit ary; bit rv; bit ri; bit rl; logic [63:0] rd;
    bit eR0; bit eR1; bit eAv; logic [31:0] eAddr; bit eId;
    bit eP0; bit eP1; bit eLast; logic [63:0] eData;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int grants, got, expOrd;
    rst = 1'b1;
    idleIn();
    mReset();
    @(negedge clk);
    rstPulse();

    tbl[0] = '{1, 'h1000, 0, 0, 1, 0, 0, 0, 0,      1, 0, 0, 0,      0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 1, 0, 0, 0, 0,           0, 0, 1, 'h1000, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 'h2000, 0, 0, 0, 0, 0,      0, 1, 0, 'h1000, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 'h3000, 0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 'h2000, 1, 0, 0, 0, 0};
    tbl[4] = '{1, 'h3000, 0, 0, 1, 0, 0, 0, 0,      1, 0, 1, 'h2000, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 1, 1, 0, 0, 'hA,         0, 0, 1, 'h3000, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 0, 1, 'hB,         0, 0, 0, 'h3000, 0, 1, 0, 0, 'hA};
    tbl[7] = '{0, 0, 0, 0, 0, 1, 1, 1, 'hC,         0, 0, 0, 'h3000, 0, 1, 0, 1, 'hB};
    tbl[8] = '{0, 0, 0, 0, 0, 1, 1, 1, 'hD,         0, 0, 0, 'h3000, 0, 0, 1, 1, 'hC};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 'h3000, 0, 0, 0, 0, 'hC};

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].v0, tbl[i].a0, tbl[i].v1, tbl[i].a1, tbl[i].ary,
            tbl[i].rv, tbl[i].ri, tbl[i].rl, tbl[i].rd);
      chk($sformatf("tbl%0d_req0Ready", i), req0Ready, 64'(tbl[i].eR0));
      chk($sformatf("tbl%0d_req1Ready", i), req1Ready, 64'(tbl[i].eR1));
      chk($sformatf("tbl%0d_arvalid", i), arvalid, 64'(tbl[i].eAv));
      chk($sformatf("tbl%0d_araddr", i), araddr, 64'(tbl[i].eAddr));
      chk($sformatf("tbl%0d_arid", i), arid, 64'(tbl[i].eId));
      chk($sformatf("tbl%0d_resp0Valid", i), resp0Valid, 64'(tbl[i].eP0));
      chk($sformatf("tbl%0d_resp1Valid", i), resp1Valid, 64'(tbl[i].eP1));
      chk($sformatf("tbl%0d_respLast", i), respLast, 64'(tbl[i].eLast));
      chk($sformatf("tbl%0d_respData", i), respData, tbl[i].eData);
      step();
    end

    // Eight-beat burst to requester 1, then a stray beat once its count is back to zero.
    rstPulse();
    apply(0, 0, 1, 'h4000, 1, 0, 0, 0, 0); step();
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) apply(0, 0, 0, 0, 0, 1, 1, (i == 7), 64'h100 + 64'(i));
      else       apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i >= 1) begin
        chk("burst_resp1Valid", resp1Valid, 64'd1);
        chk("burst_respLast", respLast, 64'(i == 8));
        chk("burst_respData", respData, 64'h100 + 64'(i - 1));
      end
      step();
    end
    apply(0, 0, 0, 0, 0, 1, 1, 1, 64'hDEAD); step();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stray_resp1Valid", resp1Valid, 64'd0);
    step();

    // Both requesters always valid: grant order.
    rstPulse();
    for (int k = 0; k < 4; k++) begin
      apply(1, 'h5000 + 32'(k), 1, 'h6000 + 32'(k), 1, 0, 0, 0, 0);
      got = req1Ready ? 1 : (req0Ready ? 0 : -1);
`ifdef RSD_MEM_READ_ARB_ROUND_ROBIN_EN
      expOrd = k % 2;
`else
      expOrd = 0;
`endif
      chk($sformatf("order_grant%0d", k), 64'(got), 64'(expOrd));
      step();
    end

    // Outstanding limit on requester 0.
    rstPulse();
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      apply(1, 'h7000, 0, 0, 1, 0, 0, 0, 0);
      grants += req0Ready ? 1 : 0;
      step();
    end
    chk("limit_grants", 64'(grants), 64'd4);
    apply(1, 'h7000, 0, 0, 1, 0, 0, 0, 0);
    chk("limit_blocked", req0Ready, 64'd0);
    step();
    apply(1, 'h7000, 0, 0, 1, 1, 0, 1, 64'h55);
    chk("limit_rlast_cycle", req0Ready, 64'd0);
    step();
    apply(1, 'h7000, 0, 0, 1, 0, 0, 0, 0);
    chk("limit_released", req0Ready, 64'd1);
    step();

    // AR stall, then reset in the middle of a burst.
    rstPulse();
    apply(1, 'h8000, 0, 0, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 5; k++) begin
      apply(1, 'h9000, 1, 'hA000, 0, 0, 0, 0, 0);
      chk("stall_araddr", araddr, 64'h8000);
      chk("stall_arid", arid, 64'd0);
      chk("stall_nogrant", 64'(req0Ready | req1Ready), 64'd0);
      step();
    end
    apply(0, 0, 0, 0, 1, 0, 0, 0, 0); step();
    apply(0, 0, 0, 0, 0, 1, 0, 0, 64'h11); step();
    apply(0, 0, 0, 0, 0, 1, 0, 0, 64'h22);
    rstPulse();
    apply(0, 0, 0, 0, 0, 1, 0, 1, 64'h33); step();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_drop", resp0Valid, 64'd0);
    step();

    // Randomised traffic against the model.
    rstPulse();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) rstPulse();
      apply($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6, $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, {$urandom, $urandom});
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
